store_commit_buffer: RTL and testbench

- Sits directly downstream of the store queue and accepts stores at ROB retirement: address, data, size.
- Holds committed-but-not-yet-written stores in an in-order FIFO.
- Drains the FIFO one at a time to the data-memory write port through a request/ready/ack handshake.
- Provides store-to-load forwarding and conflict detection against buffered stores, so that loads never read stale memory.

---
 rtl/store_commit_buffer.sv | 193 +++++++++++++++++++
 tb/tb_store_commit_buffer.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/store_commit_buffer.sv
// In-order buffer of retired stores that drains them one at a time to the
// data-memory write port and forwards buffered data to younger loads.
module store_commit_buffer #(
  parameter int SCB_SZ = 4,
  parameter int XLEN   = 32
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    retire_en,
  input  logic [XLEN-1:0]         retire_addr,
  input  logic [XLEN-1:0]         retire_data,
  input  logic [1:0]              retire_size,
  output logic                    full,
  output logic                    empty,
  output logic [$clog2(SCB_SZ):0] count,
  output logic                    overflow,
  output logic                    mem_req_valid,
  output logic [XLEN-1:0]         mem_req_addr,
  output logic [XLEN-1:0]         mem_req_data,
  output logic [3:0]              mem_req_be,
  input  logic                    mem_req_ready,
  input  logic                    mem_ack,
  input  logic                    ld_en,
  input  logic [XLEN-1:0]         ld_addr,
  input  logic [1:0]              ld_size,
  output logic                    ld_fwd_hit,
  output logic [XLEN-1:0]         ld_fwd_data,
  output logic                    ld_conflict
);

  localparam int PW = $clog2(SCB_SZ);
  localparam int CW = PW + 1;
  localparam int WA = XLEN - 2;
  localparam logic [CW-1:0] ZERO_C = {CW{1'b0}};
  localparam logic [CW-1:0] ONE_C  = CW'(1'b1);
  localparam logic [CW-1:0] FULL_C = CW'(SCB_SZ);
  localparam logic [PW-1:0] PONE_C = PW'(1'b1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [PW-1:0]     head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]     count_q, count_d;
  logic              overflow_q, overflow_d;
  logic [WA-1:0]     waddr_q [SCB_SZ];
  logic [WA-1:0]     waddr_d [SCB_SZ];
  logic [XLEN-1:0]   data_q  [SCB_SZ];
  logic [XLEN-1:0]   data_d  [SCB_SZ];
  logic [3:0]        be_q    [SCB_SZ];
  logic [3:0]        be_d    [SCB_SZ];
  logic [SCB_SZ-1:0] valid_q, valid_d;

  logic              push_s, pop_s, full_s, empty_s;
  logic [3:0]        retire_be_s, ld_mask_s;
  logic [XLEN-1:0]   retire_lane_s;
  logic [PW-1:0]     scan_idx_s, sel_s;
  logic              found_s, covers_s;

  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
    logic [3:0] m;
    case (size)
      2'd0:    m = 4'b0001 << off;
      2'd1:    m = 4'b0011 << off;
      2'd2:    m = 4'b1111;
      default: m = 4'b0000;
    endcase
    return m;
  endfunction

  // Bits above the access size are cleared so they cannot leak into other lanes.
  function automatic logic [XLEN-1:0] lane_data(input logic [XLEN-1:0] d, input logic [1:0] size,
                                                input logic [1:0] off);
    logic [XLEN-1:0] v;
    case (size)
      2'd0:    v = {{(XLEN-8){1'b0}}, d[7:0]};
      2'd1:    v = {{(XLEN-16){1'b0}}, d[15:0]};
      default: v = d;
    endcase
    return v << {off, 3'b000};
  endfunction

  assign full_s        = (count_q == FULL_C);
  assign empty_s       = (count_q == ZERO_C);
  assign full          = full_s;
  assign empty         = empty_s;
  assign count         = count_q;
  assign overflow      = overflow_q;
  assign mem_req_valid = (state_q == S_REQ);
  assign mem_req_addr  = {waddr_q[head_q], 2'b00};
  assign mem_req_data  = data_q[head_q];
  assign mem_req_be    = be_q[head_q];
  assign retire_be_s   = lane_mask(retire_size, retire_addr[1:0]);
  assign retire_lane_s = lane_data(retire_data, retire_size, retire_addr[1:0]);
  assign ld_mask_s     = lane_mask(ld_size, ld_addr[1:0]);

  // Push/pop qualification, occupancy and pointer updates.
  always_comb begin
    pop_s      = (state_q == S_WAIT) && mem_ack;
    push_s     = retire_en && (!full_s || pop_s);
    overflow_d = overflow_q | (retire_en & full_s & ~pop_s);
    head_d     = pop_s  ? head_q + PONE_C : head_q;
    tail_d     = push_s ? tail_q + PONE_C : tail_q;
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + ONE_C;
      2'b01:   count_d = count_q - ONE_C;
      default: count_d = count_q;
    endcase
  end

  // Drain state machine; a pop that leaves entries behind goes straight back to REQ.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  state_d = empty_s ? S_IDLE : S_REQ;
      S_REQ:   state_d = mem_req_ready ? S_WAIT : S_REQ;
      S_WAIT: begin
        if (mem_ack) begin
          state_d = (count_d != ZERO_C) ? S_REQ : S_IDLE;
        end else begin
          state_d = S_WAIT;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Entry storage: pop clears the head valid, push writes the tail (same slot when full).
  always_comb begin
    for (int i = 0; i < SCB_SZ; i++) begin
      waddr_d[i] = (push_s && tail_q == PW'(i)) ? retire_addr[XLEN-1:2] : waddr_q[i];
      data_d[i]  = (push_s && tail_q == PW'(i)) ? retire_lane_s : data_q[i];
      be_d[i]    = (push_s && tail_q == PW'(i)) ? retire_be_s : be_q[i];
      valid_d[i] = (push_s && tail_q == PW'(i)) |
                   (valid_q[i] & ~(pop_s && head_q == PW'(i)));
    end
  end

  // Forwarding search from oldest to youngest so the last match is the youngest.
  always_comb begin
    found_s    = 1'b0;
    sel_s      = head_q;
    scan_idx_s = head_q;
    for (int k = 0; k < SCB_SZ; k++) begin
      scan_idx_s = head_q + PW'(k);
      if (valid_q[scan_idx_s] && waddr_q[scan_idx_s] == ld_addr[XLEN-1:2] &&
          |(be_q[scan_idx_s] & ld_mask_s)) begin
        found_s = 1'b1;
        sel_s   = scan_idx_s;
      end else begin
        found_s = found_s;
        sel_s   = sel_s;
      end
    end
    covers_s    = ((be_q[sel_s] & ld_mask_s) == ld_mask_s);
    ld_fwd_hit  = ld_en & found_s & covers_s;
    ld_conflict = ld_en & found_s & ~covers_s;
    ld_fwd_data = ld_fwd_hit ? data_q[sel_s] : {XLEN{1'b0}};
  end

  // State registers; reset abandons any in-flight write.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      head_q     <= {PW{1'b0}};
      tail_q     <= {PW{1'b0}};
      count_q    <= ZERO_C;
      overflow_q <= 1'b0;
      valid_q    <= {SCB_SZ{1'b0}};
      for (int i = 0; i < SCB_SZ; i++) begin
        waddr_q[i] <= {WA{1'b0}};
        data_q[i]  <= {XLEN{1'b0}};
        be_q[i]    <= 4'b0000;
      end
    end else begin
      state_q    <= state_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      valid_q    <= valid_d;
      for (int i = 0; i < SCB_SZ; i++) begin
        waddr_q[i] <= waddr_d[i];
        data_q[i]  <= data_d[i];
        be_q[i]    <= be_d[i];
      end
    end
  end

endmodule

// File: tb/tb_store_commit_buffer.sv
// Directed bench for store_commit_buffer: drain handshake, wrap, overflow,
// push/pop while full, reset mid-write and a table of forwarding lookups.
module tb_store_commit_buffer;
  localparam int SCB_SZ = 4;
  localparam int XLEN   = 32;

  logic              clock = 1'b0;
  logic              reset;
  logic              retire_en;
  logic [XLEN-1:0]   retire_addr, retire_data;
  logic [1:0]        retire_size;
  logic              full, empty, overflow;
  logic [2:0]        count;
  logic              mem_req_valid;
  logic [XLEN-1:0]   mem_req_addr, mem_req_data;
  logic [3:0]        mem_req_be;
  logic              mem_req_ready, mem_ack;
  logic              ld_en;
  logic [XLEN-1:0]   ld_addr;
  logic [1:0]        ld_size;
  logic              ld_fwd_hit, ld_conflict;
  logic [XLEN-1:0]   ld_fwd_data;

  int checks   = 0;
  int failures = 0;

  store_commit_buffer #(.SCB_SZ(SCB_SZ), .XLEN(XLEN)) dut (
    .clock(clock), .reset(reset),
    .retire_en(retire_en), .retire_addr(retire_addr), .retire_data(retire_data),
    .retire_size(retire_size),
    .full(full), .empty(empty), .count(count), .overflow(overflow),
    .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr),
    .mem_req_data(mem_req_data), .mem_req_be(mem_req_be),
    .mem_req_ready(mem_req_ready), .mem_ack(mem_ack),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_size(ld_size),
    .ld_fwd_hit(ld_fwd_hit), .ld_fwd_data(ld_fwd_data), .ld_conflict(ld_conflict)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        en;
    logic [31:0] addr;
    logic [1:0]  size;
    logic        hit;
    logic        conf;
    logic [31:0] data;
  } fwd_vec_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  size;
    logic [31:0] exp_addr;
    logic [31:0] exp_data;
    logic [3:0]  exp_be;
  } st_vec_t;

  fwd_vec_t fv [12];
  st_vec_t  sv [5];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
    retire_en   = 1'b1;
    retire_addr = a;
    retire_data = d;
    retire_size = s;
    step();
    retire_en   = 1'b0;
  endtask

  task automatic wait_req(input string tag);
    int n = 0;
    while (!mem_req_valid && n < 20) begin
      step();
      n++;
    end
    chk($sformatf("%s_req_timeout", tag), mem_req_valid, 1);
  endtask

  task automatic drain_one(input string tag, input logic [31:0] ea, input logic [31:0] ed,
                           input logic [3:0] ebe);
    wait_req(tag);
    chk($sformatf("%s_addr", tag), mem_req_addr, ea);
    chk($sformatf("%s_data", tag), mem_req_data, ed);
    chk($sformatf("%s_be", tag), mem_req_be, ebe);
    mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
    chk($sformatf("%s_wait_valid", tag), mem_req_valid, 0);
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
  endtask

  task automatic ld_check(input string tag, input logic [31:0] a, input logic [1:0] s,
                          input logic ehit, input logic econf, input logic [31:0] ed);
    ld_en   = 1'b1;
    ld_addr = a;
    ld_size = s;
    #1;
    chk($sformatf("%s_hit", tag), ld_fwd_hit, ehit);
    chk($sformatf("%s_conflict", tag), ld_conflict, econf);
    if (ehit) chk($sformatf("%s_data", tag), ld_fwd_data, ed);
    ld_en = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit saw_req;
    reset = 1'b1;
    retire_en = 1'b0; retire_addr = 32'h0; retire_data = 32'h0; retire_size = 2'd0;
    mem_req_ready = 1'b0; mem_ack = 1'b0;
    ld_en = 1'b0; ld_addr = 32'h0; ld_size = 2'd0;
    step();
    step();

    // ---- reset state
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_count", count, 0);
    chk("rst_valid", mem_req_valid, 0);
    chk("rst_overflow", overflow, 0);
    ld_check("rst_ld", 32'h0, 2'd2, 1'b0, 1'b0, 32'h0);
    reset = 1'b0;
    step();

    // ---- single word drain, two-cycle latency, stable while ready low
    push(32'h100, 32'hDEADBEEF, 2'd2);
    chk("w1_count", count, 1);
    chk("w1_lat1_valid", mem_req_valid, 0);
    step();
    chk("w1_lat2_valid", mem_req_valid, 1);
    chk("w1_addr", mem_req_addr, 32'h100);
    chk("w1_data", mem_req_data, 32'hDEADBEEF);
    chk("w1_be", mem_req_be, 4'b1111);
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("w1_hold%0d_valid", i), mem_req_valid, 1);
      chk($sformatf("w1_hold%0d_addr", i), mem_req_addr, 32'h100);
      chk($sformatf("w1_hold%0d_data", i), mem_req_data, 32'hDEADBEEF);
    end
    mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
    chk("w1_wait_valid", mem_req_valid, 0);
    chk("w1_wait_count", count, 1);
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    chk("w1_empty", empty, 1);
    chk("w1_count0", count, 0);
    step();
    chk("w1_idle_valid", mem_req_valid, 0);

    // ---- fill, overflow, drain in order, then wrap
    sv[0] = '{32'h1000, 32'h01020304, 2'd2, 32'h1000, 32'h01020304, 4'b1111};
    sv[1] = '{32'h1011, 32'h0000005A, 2'd0, 32'h1010, 32'h00005A00, 4'b0010};
    sv[2] = '{32'h1022, 32'h0000BEEF, 2'd1, 32'h1020, 32'hBEEF0000, 4'b1100};
    sv[3] = '{32'h1033, 32'h000000C3, 2'd0, 32'h1030, 32'hC3000000, 4'b1000};
    sv[4] = '{32'h1040, 32'hFFFFFFFF, 2'd2, 32'h1040, 32'hFFFFFFFF, 4'b1111};
    for (int i = 0; i < 4; i++) push(sv[i].addr, sv[i].data, sv[i].size);
    chk("fill_full", full, 1);
    chk("fill_count", count, 4);
    chk("fill_ovf_before", overflow, 0);
    push(sv[4].addr, sv[4].data, sv[4].size);
    chk("ovf_flag", overflow, 1);
    chk("ovf_count", count, 4);
    for (int i = 0; i < 4; i++)
      drain_one($sformatf("fill%0d", i), sv[i].exp_addr, sv[i].exp_data, sv[i].exp_be);
    chk("fill_drained", empty, 1);
    chk("ovf_sticky", overflow, 1);
    for (int i = 0; i < 4; i++) push(32'h2000 + 32'(4 * i), 32'hA0000000 + 32'(i), 2'd2);
    chk("wrap_full", full, 1);
    for (int i = 0; i < 4; i++)
      drain_one($sformatf("wrap%0d", i), 32'h2000 + 32'(4 * i), 32'hA0000000 + 32'(i), 4'b1111);
    chk("wrap_empty", empty, 1);

    // ---- push and pop in the same cycle while full
    for (int i = 0; i < 4; i++) push(32'h3000 + 32'(4 * i), 32'h30 + 32'(i), 2'd2);
    wait_req("pp");
    chk("pp_head_addr", mem_req_addr, 32'h3000);
    mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
    mem_ack = 1'b1;
    retire_en = 1'b1; retire_addr = 32'h3010; retire_data = 32'h34; retire_size = 2'd2;
    step();
    mem_ack = 1'b0;
    retire_en = 1'b0;
    chk("pp_count", count, 4);
    chk("pp_full", full, 1);
    for (int i = 1; i < 5; i++)
      drain_one($sformatf("pp%0d", i), 32'h3000 + 32'(4 * i), 32'h30 + 32'(i), 4'b1111);
    chk("pp_empty", empty, 1);

    // ---- reset while a write is in WAIT
    for (int i = 0; i < 3; i++) push(32'h4000 + 32'(4 * i), 32'h40 + 32'(i), 2'd2);
    wait_req("rw");
    mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
    chk("rw_in_wait", mem_req_valid, 0);
    #2 reset = 1'b1;
    #1;
    chk("rw_valid", mem_req_valid, 0);
    chk("rw_empty", empty, 1);
    chk("rw_count", count, 0);
    chk("rw_overflow", overflow, 0);
    step();
    reset = 1'b0;
    saw_req = 1'b0;
    mem_ack = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      mem_ack = 1'b0;
      if (mem_req_valid) saw_req = 1'b1;
    end
    chk("rw_no_write", saw_req, 0);
    chk("rw_still_empty", empty, 1);

    // ---- forwarding table against a static full buffer
    push(32'h203, 32'hAA, 2'd0);
    push(32'h200, 32'h11223344, 2'd2);
    push(32'h301, 32'h55, 2'd0);
    push(32'h406, 32'hCAFE, 2'd1);
    fv[0]  = '{1'b1, 32'h203, 2'd0, 1'b1, 1'b0, 32'h11223344};
    fv[1]  = '{1'b1, 32'h200, 2'd2, 1'b1, 1'b0, 32'h11223344};
    fv[2]  = '{1'b1, 32'h202, 2'd1, 1'b1, 1'b0, 32'h11223344};
    fv[3]  = '{1'b1, 32'h300, 2'd2, 1'b0, 1'b1, 32'h0};
    fv[4]  = '{1'b1, 32'h302, 2'd0, 1'b0, 1'b0, 32'h0};
    fv[5]  = '{1'b1, 32'h301, 2'd0, 1'b1, 1'b0, 32'h00005500};
    fv[6]  = '{1'b1, 32'h406, 2'd1, 1'b1, 1'b0, 32'hCAFE0000};
    fv[7]  = '{1'b1, 32'h404, 2'd2, 1'b0, 1'b1, 32'h0};
    fv[8]  = '{1'b1, 32'h405, 2'd0, 1'b0, 1'b0, 32'h0};
    fv[9]  = '{1'b1, 32'h500, 2'd2, 1'b0, 1'b0, 32'h0};
    fv[10] = '{1'b0, 32'h200, 2'd2, 1'b0, 1'b0, 32'h0};
    fv[11] = '{1'b1, 32'h300, 2'd1, 1'b0, 1'b1, 32'h0};
    for (int i = 0; i < 12; i++) begin
      ld_en   = fv[i].en;
      ld_addr = fv[i].addr;
      ld_size = fv[i].size;
      #1;
      chk($sformatf("fwd%0d_hit", i), ld_fwd_hit, fv[i].hit);
      chk($sformatf("fwd%0d_conflict", i), ld_conflict, fv[i].conf);
      if (fv[i].hit) chk($sformatf("fwd%0d_data", i), ld_fwd_data, fv[i].data);
      step();
    end
    ld_en = 1'b0;
    drain_one("fd0", 32'h200, 32'hAA000000, 4'b1000);
    drain_one("fd1", 32'h200, 32'h11223344, 4'b1111);
    drain_one("fd2", 32'h300, 32'h00005500, 4'b0010);
    drain_one("fd3", 32'h404, 32'hCAFE0000, 4'b1100);

    // ---- youngest overlapping entry decides, head stays visible in WAIT
    push(32'h600, 32'hA1B2C3D4, 2'd2);
    push(32'h601, 32'h77, 2'd0);
    ld_check("yg_word", 32'h600, 2'd2, 1'b0, 1'b1, 32'h0);
    ld_check("yg_b601", 32'h601, 2'd0, 1'b1, 1'b0, 32'h00007700);
    ld_check("yg_b600", 32'h600, 2'd0, 1'b1, 1'b0, 32'hA1B2C3D4);
    wait_req("yg");
    mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
    ld_check("yg_wait_b600", 32'h600, 2'd0, 1'b1, 1'b0, 32'hA1B2C3D4);
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    ld_check("yg_popped_b600", 32'h600, 2'd0, 1'b0, 1'b0, 32'h0);
    ld_check("yg_popped_word", 32'h600, 2'd2, 1'b0, 1'b1, 32'h0);
    drain_one("yg_last", 32'h600, 32'h00007700, 4'b0010);
    chk("yg_empty", empty, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
